// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared types and constants for the serial bus forward and return
//            paths: master and slave select codes, return-mux state encoding
//            and the bus idle level.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  typedef enum logic [1:0] {
    M_NONE = 2'b00,
    M1     = 2'b01,
    M2     = 2'b10,
    M_BAD  = 2'b11
  } master_sel_t;

  typedef enum logic [1:0] {
    S_NONE = 2'b00,
    S1     = 2'b01,
    S2     = 2'b10,
    S3     = 2'b11
  } slave_sel_t;

  typedef enum logic [1:0] {
    RET_IDLE   = 2'b00,
    RET_ACTIVE = 2'b01,
    RET_FLUSH  = 2'b10
  } ret_state_t;

  localparam logic BUS_IDLE_LEVEL = 1'b1;

  // A route needs exactly one master bit set and a non-zero slave code.
  function automatic logic route_is_legal(input master_sel_t m, input slave_sel_t s);
    return ((m == M1) || (m == M2)) && (s != S_NONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : idle_timer
// Purpose  : Saturating up-counter with synchronous clear and increment and a
//            terminal-count flag. Shared by the forward and return paths as a
//            line-silence watchdog.
// Ports    : clk, rstN  - clock, synchronous active-low reset
//            clr_i      - clear count to zero (has priority over inc_i)
//            inc_i      - increment count, holding at all-ones
//            tc_o       - count currently equals TERMINAL
// Revision : 1.0 - initial release
// ============================================================================
module idle_timer #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 7
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] TC_VAL  = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] SAT_VAL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != SAT_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/slave_return_mux.sv
`default_nettype none
// ============================================================================
// Module   : slave_return_mux
// Purpose  : Registered return-path router. Latches the arbiter's route,
//            forwards the selected slave's serial line to the selected master
//            with one cycle of latency, flags illegal requests and aborts a
//            route whose slave line stops toggling.
// Ports    : clk, rstN                  - clock, synchronous active-low reset
//            master[1:0], slave[1:0]    - route selects, valid with route_req
//            route_req, route_done      - one-cycle start / end strobes
//            slave{1,2,3}_tx            - slave serial outputs
//            master{1,2}_rx             - master serial inputs
//            busy                       - route held (ACTIVE or FLUSH)
//            route_err, timeout         - one-cycle event pulses
// Revision : 1.0 - initial release
// ============================================================================
module slave_return_mux
  import bus_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter logic IDLE_LEVEL     = BUS_IDLE_LEVEL
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] master,
  input  logic [1:0] slave,
  input  logic       route_req,
  input  logic       route_done,
  input  logic       slave1_tx,
  input  logic       slave2_tx,
  input  logic       slave3_tx,
  output logic       master1_rx,
  output logic       master2_rx,
  output logic       busy,
  output logic       route_err,
  output logic       timeout
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  ret_state_t  state_q, state_d;
  master_sel_t msel_q,  msel_d;
  slave_sel_t  ssel_q,  ssel_d;
  logic        last_q,  last_d;   // previous sample of the routed slave line
  logic        m1_q,    m1_d;
  logic        m2_q,    m2_d;
  logic        busy_q,  busy_d;
  logic        err_q,   err_d;
  logic        to_q,    to_d;

  logic        w_sel_line;
  logic        w_req_line;
  logic        w_edge;
  logic        w_active;
  logic        w_tc;
  logic        w_timeout;

  function automatic logic pick_line(input slave_sel_t s, input logic l1,
                                     input logic l2, input logic l3);
    case (s)
      S1:      return l1;
      S2:      return l2;
      S3:      return l3;
      default: return IDLE_LEVEL;
    endcase
  endfunction

  assign w_sel_line = pick_line(ssel_q, slave1_tx, slave2_tx, slave3_tx);
  // The requested slave's line is captured at setup so the very first ACTIVE
  // cycle already has a reference for edge detection.
  assign w_req_line = pick_line(slave_sel_t'(slave), slave1_tx, slave2_tx, slave3_tx);
  assign w_active   = (state_q == RET_ACTIVE);
  assign w_edge     = w_active && (w_sel_line != last_q);
  assign w_timeout  = w_active && w_tc && !w_edge;

  // Outside ACTIVE the timer is held at zero, which also covers the clear
  // required when a new route is accepted.
  idle_timer #(
    .WIDTH    (TIMER_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_idle_timer (
    .clk   (clk),
    .rstN  (rstN),
    .clr_i (!w_active || w_edge),
    .inc_i (w_active && !w_edge),
    .tc_o  (w_tc)
  );

  always_comb begin
    state_d = state_q;
    msel_d  = msel_q;
    ssel_d  = ssel_q;
    last_d  = last_q;
    m1_d    = IDLE_LEVEL;
    m2_d    = IDLE_LEVEL;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      RET_IDLE: begin
        if (route_req) begin
          if (route_is_legal(master_sel_t'(master), slave_sel_t'(slave))) begin
            state_d = RET_ACTIVE;
            msel_d  = master_sel_t'(master);
            ssel_d  = slave_sel_t'(slave);
            last_d  = w_req_line;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RET_ACTIVE: begin
        busy_d = 1'b1;
        last_d = w_sel_line;
        // route_done takes priority over a coincident silence abort.
        if (route_done || w_timeout) begin
          state_d = RET_FLUSH;
          msel_d  = M_NONE;
          ssel_d  = S_NONE;
          to_d    = !route_done;
        end else if (msel_q == M1) begin
          m1_d = w_sel_line;
        end else begin
          m2_d = w_sel_line;
        end
      end
      RET_FLUSH: begin
        state_d = RET_IDLE;
      end
      default: begin
        state_d = RET_IDLE;
        msel_d  = M_NONE;
        ssel_d  = S_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= RET_IDLE;
      msel_q  <= M_NONE;
      ssel_q  <= S_NONE;
      last_q  <= IDLE_LEVEL;
      m1_q    <= IDLE_LEVEL;
      m2_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      msel_q  <= msel_d;
      ssel_q  <= ssel_d;
      last_q  <= last_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign master1_rx = m1_q;
  assign master2_rx = m2_q;
  assign busy       = busy_q;
  assign route_err  = err_q;
  assign timeout    = to_q;

endmodule
`default_nettype wire

// File: tb/tb_slave_return_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_return_mux
// Purpose  : Self-checking bench for slave_return_mux with a behavioural
//            reference model of the route/forward/teardown/abort rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_return_mux;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [1:0] master = 2'b00;
  logic [1:0] slave = 2'b00;
  logic       route_req = 1'b0;
  logic       route_done = 1'b0;
  logic       s1 = 1'b1, s2 = 1'b1, s3 = 1'b1;
  logic       master1_rx, master2_rx, busy, route_err, timeout;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = no route, 1 = forwarding, 2 = teardown cycle.
  int       mode = 0;
  int       rm = 0, rs = 0;
  int       quiet = 0;
  bit       prev = 1'b1;
  logic [4:0] exp_vec = 5'b11000;  // {m1_rx, m2_rx, busy, route_err, timeout}

  always #5 clk = ~clk;

  slave_return_mux #(.TIMEOUT_CYCLES(TO), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rstN(rstN), .master(master), .slave(slave),
    .route_req(route_req), .route_done(route_done),
    .slave1_tx(s1), .slave2_tx(s2), .slave3_tx(s3),
    .master1_rx(master1_rx), .master2_rx(master2_rx),
    .busy(busy), .route_err(route_err), .timeout(timeout)
  );

  function automatic logic [4:0] obs();
    return {master1_rx, master2_rx, busy, route_err, timeout};
  endfunction

  function automatic bit line_of(input int s);
    return (s == 1) ? s1 : (s == 2) ? s2 : s3;
  endfunction

  // Apply the spec's rules to the inputs present before the edge, then clock.
  task automatic tick();
    logic [4:0] n;
    bit ln;
    n = 5'b11000;
    if (!rstN) begin
      mode = 0;
    end else begin
      case (mode)
        0: if (route_req) begin
             if ((master == 2'd1 || master == 2'd2) && slave != 2'd0) begin
               mode = 1; rm = int'(master); rs = int'(slave);
               quiet = 0; prev = line_of(rs); n[2] = 1'b1;
             end else begin
               n[1] = 1'b1;
             end
           end
        1: begin
             ln = line_of(rs);
             quiet = (ln != prev) ? 0 : quiet + 1;
             prev = ln;
             n[2] = 1'b1;
             if (route_done) mode = 2;
             else if (quiet >= TO) begin mode = 2; n[0] = 1'b1; end
             else if (rm == 1) n[4] = ln;
             else n[3] = ln;
           end
        default: mode = 0;
      endcase
    end
    exp_vec = n;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lines();
    s1 = 1'($urandom); s2 = 1'($urandom); s3 = 1'($urandom);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_lines();
      route_req = 1'($urandom); master = 2'($urandom); slave = 2'($urandom);
      tick();
      checks++;
      if (obs() !== 5'b11000) begin
        failures++;
        $display("FAIL reset[%0d]: got %b want 11000", i, obs());
      end
    end
    route_req = 1'b0;
    rstN = 1'b1;
  endtask

  task automatic test_route_m2_s3();
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    master = 2'b10; slave = 2'b11; route_req = 1'b1; s3 = 1'b0;
    tick();
    route_req = 1'b0;
    checks++;
    if (obs() !== exp_vec) begin
      failures++;
      $display("FAIL route_setup: got %b want %b", obs(), exp_vec);
    end
    for (int i = 0; i < 5; i++) begin
      s3 = pat[i]; s1 = 1'($urandom); s2 = 1'($urandom);
      tick();
      checks++;
      if (obs() !== exp_vec || master2_rx !== pat[i] || master1_rx !== 1'b1) begin
        failures++;
        $display("FAIL route_pattern[%0d]: got %b want %b (bit %b)", i, obs(), exp_vec, pat[i]);
      end
    end
    route_done = 1'b1;
    tick();
    route_done = 1'b0;
    checks++;
    if (obs() !== 5'b11100) begin
      failures++;
      $display("FAIL route_flush: got %b want 11100", obs());
    end
    tick();
    checks++;
    if (obs() !== 5'b11000) begin
      failures++;
      $display("FAIL route_idle: got %b want 11000", obs());
    end
  endtask

  task automatic test_illegal();
    logic [3:0] codes [3] = '{4'b11_01, 4'b01_00, 4'b00_10};
    for (int i = 0; i < 3; i++) begin
      {master, slave} = codes[i]; route_req = 1'b1; rand_lines();
      tick();
      checks++;
      if (obs() !== exp_vec || route_err !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal[%0d]: got %b want %b", i, obs(), exp_vec);
      end
    end
    route_req = 1'b0;
    tick();
    checks++;
    if (obs() !== 5'b11000) begin
      failures++;
      $display("FAIL illegal_end: got %b want 11000", obs());
    end
  endtask

  task automatic test_req_in_active();
    master = 2'b01; slave = 2'b10; route_req = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      route_req = (i < 3); master = 2'b10; slave = 2'(i[1:0]);
      rand_lines();
      tick();
      checks++;
      if (obs() !== exp_vec || route_err !== 1'b0) begin
        failures++;
        $display("FAIL req_in_active[%0d]: got %b want %b", i, obs(), exp_vec);
      end
    end
    route_req = 1'b0; route_done = 1'b1;
    tick();
    route_done = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    master = 2'b10; slave = 2'b01; route_req = 1'b1;
    tick();
    route_req = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_lines(); tick(); end
    route_done = 1'b1;
    tick();
    route_done = 1'b0;
    tick();
    master = 2'b01; slave = 2'b01; route_req = 1'b1;
    tick();
    route_req = 1'b0;
    checks++;
    if (obs() !== exp_vec || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: got %b want %b", obs(), exp_vec);
    end
    for (int i = 0; i < 4; i++) begin
      rand_lines();
      tick();
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL b2b_data[%0d]: got %b want %b", i, obs(), exp_vec);
      end
    end
    route_done = 1'b1;
    tick();
    route_done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    s2 = 1'b0;
    master = 2'b01; slave = 2'b10; route_req = 1'b1;
    tick();
    route_req = 1'b0;
    for (int i = 0; i < TO + 4; i++) begin
      s1 = 1'($urandom); s3 = 1'($urandom);
      tick();
      if (timeout === 1'b1) pulses++;
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL timeout[%0d]: got %b want %b", i, obs(), exp_vec);
      end
    end
    checks++;
    if (pulses != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_count: got pulses=%0d busy=%b want 1 0", pulses, busy);
    end
  endtask

  task automatic test_timeout_vs_done();
    int pulses = 0;
    s1 = 1'b1;
    master = 2'b10; slave = 2'b01; route_req = 1'b1;
    tick();
    route_req = 1'b0;
    for (int i = 0; i < TO + 3; i++) begin
      route_done = (i == TO - 1);
      tick();
      if (timeout === 1'b1) pulses++;
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL done_wins[%0d]: got %b want %b", i, obs(), exp_vec);
      end
    end
    route_done = 1'b0;
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL done_wins_count: got pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    master = 2'b01; slave = 2'b11; route_req = 1'b1;
    tick();
    route_req = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_lines(); tick(); end
    rstN = 1'b0; route_done = 1'b1;
    tick();
    rstN = 1'b1; route_done = 1'b0;
    checks++;
    if (obs() !== 5'b11000) begin
      failures++;
      $display("FAIL reset_mid: got %b want 11000", obs());
    end
    rand_lines();
    tick();
    checks++;
    if (obs() !== 5'b11000) begin
      failures++;
      $display("FAIL reset_mid_after: got %b want 11000", obs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      route_req  = ($urandom_range(0, 3) == 0);
      route_done = ($urandom_range(0, 15) == 0);
      master = 2'($urandom); slave = 2'($urandom);
      if ($urandom_range(0, 9) == 0) s1 = ~s1;
      if ($urandom_range(0, 9) == 0) s2 = ~s2;
      if ($urandom_range(0, 9) == 0) s3 = ~s3;
      tick();
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL random[%0d]: got %b want %b", i, obs(), exp_vec);
      end
    end
    route_req = 1'b0; route_done = 1'b0;
  endtask

  initial begin
    test_reset();
    tick();
    test_route_m2_s3();
    test_illegal();
    test_req_in_active();
    test_back_to_back();
    test_timeout();
    tick();
    test_timeout_vs_done();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
